// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_CORE_UP = 2'd2,
      ST_RUN     = 2'd3
   } seq_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_HOLD_CYC    = 16;
   localparam int DEF_PERIPH_DLY  = 8;
   localparam int CNT_W           = 8;

endpackage

// File: rtl/rst_seq_rst_sync.sv
// Reset-deassertion synchronizer: asserts asynchronously, releases after SYNC_STAGES edges.
module rst_sync
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   output logic sync_rst
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   assign sync_rst = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases core reset, then peripheral reset, with software restart.
//
// state   | meaning
// SYNC    | waiting for synchronized rst deassertion; all resets asserted
// HOLD    | both resets asserted, counting HOLD_CYC
// CORE_UP | core released, peripheral held, counting PERIPH_DLY
// RUN     | everything released, ready high
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int HOLD_CYC    = DEF_HOLD_CYC,
   parameter int PERIPH_DLY  = DEF_PERIPH_DLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_rst_req,
   output logic             core_rst_n,
   output logic             periph_rst_n,
   output logic             ready,
   output logic [CNT_W-1:0] sw_rst_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY - 1);
   localparam logic [CNT_W-1:0] SW_CNT_MAX  = '1;

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             core_q, core_d;
   logic             periph_q, periph_d;
   logic             ready_q, ready_d;
   logic             sw_q;
   logic [CNT_W-1:0] sw_cnt_q;
   logic             sync_rst;

   rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
      .clk      (clk),
      .rst      (rst),
      .sync_rst (sync_rst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SYNC;
         cnt_q    <= '0;
         core_q   <= 1'b0;
         periph_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         core_q   <= core_d;
         periph_q <= periph_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      core_d   = core_q;
      periph_d = periph_q;
      ready_d  = ready_q;
      case (state_q)
         ST_SYNC: begin
            core_d   = 1'b0;
            periph_d = 1'b0;
            ready_d  = 1'b0;
            if (!sync_rst) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            periph_d = 1'b0;
            ready_d  = 1'b0;
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_CORE_UP;
               cnt_d   = '0;
               core_d  = 1'b1;
            end else begin
               core_d  = 1'b0;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_CORE_UP: begin
            if (cnt_q == PERIPH_LAST) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               periph_d = 1'b1;
               ready_d  = 1'b1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
            end
         end
         ST_RUN: ;
         default: state_d = ST_SYNC;
      endcase
      // A software request restarts the hold phase from any state past SYNC.
      if (sw_rst_req && (state_q != ST_SYNC)) begin
         state_d  = ST_HOLD;
         cnt_d    = '0;
         core_d   = 1'b0;
         periph_d = 1'b0;
         ready_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_q     <= 1'b0;
         sw_cnt_q <= '0;
      end else begin
         sw_q <= sw_rst_req;
         if (sw_rst_req && !sw_q && (state_q != ST_SYNC) && (sw_cnt_q != SW_CNT_MAX))
            sw_cnt_q <= sw_cnt_q + 1'b1;
      end
   end

   assign core_rst_n   = core_q;
   assign periph_rst_n = periph_q;
   assign ready        = ready_q;
   assign sw_rst_cnt   = sw_cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: edge-count reference model, literal timing checks, random stimulus.
module tb_rst_seq;

   localparam int SS = 2;
   localparam int HC = 16;
   localparam int PD = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       core_rst_n, periph_rst_n, ready;
   logic [7:0] sw_rst_cnt;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   // model: edges since rst release, edge at which release counting last restarted
   int m_k    = 0;
   int m_rel  = -1;
   int m_cnt  = 0;
   bit m_prev = 1'b0;

   rst_seq #(.SYNC_STAGES(SS), .HOLD_CYC(HC), .PERIPH_DLY(PD)) dut (
      .clk          (clk),
      .rst          (rst),
      .sw_rst_req   (sw_rst_req),
      .core_rst_n   (core_rst_n),
      .periph_rst_n (periph_rst_n),
      .ready        (ready),
      .sw_rst_cnt   (sw_rst_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_k    = 0;
         m_rel  = -1;
         m_cnt  = 0;
         m_prev = 1'b0;
      end else begin
         m_k++;
         if (m_k == SS + 1) m_rel = m_k;
         if (sw_rst_req && m_k >= SS + 2) begin
            if (!m_prev && m_cnt < 255) m_cnt++;
            m_rel = m_k;
         end
         m_prev = sw_rst_req;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int e_core, e_per;
         e_core = (m_rel >= 0 && m_k >= m_rel + HC) ? 1 : 0;
         e_per  = (m_rel >= 0 && m_k >= m_rel + HC + PD) ? 1 : 0;
         chk("model core_rst_n", int'(core_rst_n), e_core);
         chk("model periph_rst_n", int'(periph_rst_n), e_per);
         chk("model ready", int'(ready), e_per);
         chk("model sw_rst_cnt", int'(sw_rst_cnt), m_cnt);
      end
   end

   always @(core_rst_n or periph_rst_n) begin
      if (chk_en) begin
         n_total++;
         assert (!(periph_rst_n === 1'b1 && core_rst_n === 1'b0)) n_pass++;
         else $display("FAIL order: periph_rst_n=%b core_rst_n=%b at t=%0t", periph_rst_n, core_rst_n, $time);
      end
   end

   task automatic sw_pulse(input int len);
      sw_rst_req = 1'b1;
      repeat (len) @(negedge clk);
      sw_rst_req = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;

      // power-up
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (18) @(negedge clk);
      chk("pwr core@18", int'(core_rst_n), 0);
      @(negedge clk);
      chk("pwr core@19", int'(core_rst_n), 1);
      repeat (7) @(negedge clk);
      chk("pwr periph@26", int'(periph_rst_n), 0);
      @(negedge clk);
      chk("pwr periph@27", int'(periph_rst_n), 1);
      chk("pwr ready@27", int'(ready), 1);
      chk("pwr cnt", int'(sw_rst_cnt), 0);
      repeat (5) @(negedge clk);

      // single-cycle sw pulse
      sw_pulse(1);
      chk("pulse core@N", int'(core_rst_n), 0);
      chk("pulse ready@N", int'(ready), 0);
      repeat (15) @(negedge clk);
      chk("pulse core@N+15", int'(core_rst_n), 0);
      @(negedge clk);
      chk("pulse core@N+16", int'(core_rst_n), 1);
      repeat (7) @(negedge clk);
      chk("pulse periph@N+23", int'(periph_rst_n), 0);
      @(negedge clk);
      chk("pulse periph@N+24", int'(periph_rst_n), 1);
      chk("pulse cnt", int'(sw_rst_cnt), 1);

      // held request, 10 samples
      sw_pulse(10);
      chk("held core@M", int'(core_rst_n), 0);
      repeat (15) @(negedge clk);
      chk("held core@M+15", int'(core_rst_n), 0);
      @(negedge clk);
      chk("held core@M+16", int'(core_rst_n), 1);
      repeat (8) @(negedge clk);
      chk("held ready@M+24", int'(ready), 1);
      chk("held cnt", int'(sw_rst_cnt), 2);

      // async reset during CORE_UP
      sw_pulse(1);
      repeat (19) @(negedge clk);
      chk("async pre core", int'(core_rst_n), 1);
      #2 rst = 1'b1;
      #1 chk("async core immediate", int'(core_rst_n), 0);
      chk("async cnt immediate", int'(sw_rst_cnt), 0);
      #1 rst = 1'b0;
      repeat (18) @(negedge clk);
      chk("async core@18", int'(core_rst_n), 0);
      @(negedge clk);
      chk("async core@19", int'(core_rst_n), 1);
      repeat (8) @(negedge clk);
      chk("async ready@27", int'(ready), 1);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         int act;
         act = $urandom_range(0, 9);
         if (act == 0) begin
            #2 rst = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
         end else if (act <= 3) begin
            sw_pulse($urandom_range(1, 4));
         end else begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
         end
      end

      // saturation
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      repeat (30) @(negedge clk);
      for (int i = 0; i < 260; i++) begin
         sw_pulse(1);
         @(negedge clk);
      end
      chk("sat cnt", int'(sw_rst_cnt), 255);
      repeat (30) @(negedge clk);
      chk("sat ready", int'(ready), 1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter: SYNC_STAGES, 2, depth of reset-deassertion synchronizer (legal 2..4).
REQ-002 Parameter: HOLD_CYC, 16, cycles both outputs stay asserted before core release (legal 1..255).
REQ-003 Parameter: PERIPH_DLY, 8, cycles from core release to peripheral release (legal 1..255).
REQ-004 Port: clk  input  1  single clock; all state changes on posedge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: sw_rst_req  input  1  synchronous software reset request, active-high, level-sampled.
REQ-007 Port: core_rst_n  output  1  registered active-low reset for core logic (e.g. ALU).
REQ-008 Port: periph_rst_n  output  1  registered active-low reset for peripheral/stimulus logic.
REQ-009 Port: ready  output  1  high when both resets are released and the sequence is complete.
REQ-010 Port: sw_rst_cnt  output  8  count of accepted software reset requests, saturating.

Function
REQ-011 The FSM SHALL have states SYNC, HOLD, CORE_UP, RUN.
REQ-012 SYNC: wait for the synchronizer output to read low; the next edge enters HOLD with the counter cleared.
REQ-013 HOLD: core_rst_n=0, periph_rst_n=0; the counter increments each cycle; on reaching HOLD_CYC, go to CORE_UP and drive core_rst_n=1 on the same edge.
REQ-014 CORE_UP: core_rst_n=1, periph_rst_n=0; the counter restarts at 0; on reaching PERIPH_DLY, go to RUN and drive periph_rst_n=1 and ready=1 on the same edge.
REQ-015 RUN: all released; the FSM stays in RUN until rst or sw_rst_req.
REQ-016 Release timing after rst falls, with posedge 1 as the first posedge with rst low: core_rst_n rises at posedge SYNC_STAGES+1+HOLD_CYC; periph_rst_n and ready rise at posedge SYNC_STAGES+1+HOLD_CYC+PERIPH_DLY (defaults: 19 and 27).
REQ-017 sw_rst_req sampled high at posedge N in HOLD, CORE_UP or RUN SHALL enter HOLD with the counter cleared; core_rst_n, periph_rst_n and ready are low after edge N.
REQ-018 sw_rst_req sampled high at posedge N in SYNC SHALL be ignored.
REQ-019 sw_rst_req held high SHALL keep the FSM in HOLD with the counter cleared; release counting starts on the first edge sampling it low.
REQ-020 After a sw request, core_rst_n SHALL rise at posedge M+HOLD_CYC and periph_rst_n/ready at posedge M+HOLD_CYC+PERIPH_DLY, where M is the last posedge sampling sw_rst_req high.
REQ-021 sw_rst_cnt SHALL increment by 1 on each 0->1 transition of sampled sw_rst_req outside SYNC, saturate at 255, and be cleared only by rst.
REQ-022 Outputs SHALL be glitch-free register outputs; no combinational path from any input to any output.
REQ-023 The release order SHALL always be core before peripheral; periph_rst_n=1 with core_rst_n=0 is illegal in every state.

Reset
REQ-024 rst high SHALL immediately and asynchronously force core_rst_n=0, periph_rst_n=0, ready=0, sw_rst_cnt=0, state SYNC, counter 0, and all synchronizer flops to 1.
REQ-025 rst asserted mid-sequence (any state) SHALL abort the sequence; on deassertion the sequence restarts from SYNC per REQ-016.
REQ-026 rst deassertion SHALL be synchronized through SYNC_STAGES flops before the FSM reacts.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit) and the default values of HOLD_CYC, PERIPH_DLY and SYNC_STAGES.
REQ-028 The reset-deassertion synchronizer SHALL be a separate sub-module, rst_sync, parameterized by SYNC_STAGES.
REQ-029 The release counter SHALL be 8 bits wide, shared by HOLD and CORE_UP.

Verification
REQ-030 Power-up: rst=1 for 3 cycles then 0 -> core_rst_n rises at posedge 19, periph_rst_n and ready at posedge 27, sw_rst_cnt=0.
REQ-031 sw pulse: in RUN, sw_rst_req=1 for 1 cycle at posedge N -> all outputs low after N, core up at N+16, periph/ready up at N+24, sw_rst_cnt=1.
REQ-032 Held request: sw_rst_req high for 10 cycles (last sample M) -> outputs low throughout, core up at M+16, periph at M+24, sw_rst_cnt incremented once.
REQ-033 Async reset mid-sequence: rst pulsed high between clock edges during CORE_UP -> core_rst_n falls immediately with no clock, then the full sequence repeats per REQ-030.
REQ-034 Saturation: 260 separate sw pulses -> sw_rst_cnt=255; no wrap.
REQ-035 Ordering check: an assertion over all tests that periph_rst_n never equals 1 while core_rst_n equals 0.
